// File: rtl/mips_div_pkg.sv
// Shared types and constants for the iterative MIPS DIV/DIVU unit.
package mips_div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_LAT   = DIV_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  always_comb begin
    // rem < divisor on entry, so the shifted value needs only one extra bit
    rem_shift = {rem, quo[WIDTH-1]};
    diff      = rem_shift - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/mips_divider.sv
// Fixed-latency signed/unsigned 32-bit divider: magnitude conversion, WIDTH restoring
// iterations, sign fix-up; Hi = remainder, Lo = quotient.
module mips_divider
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validIn,
  input  logic             sign,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             validOut,
  output logic             busy,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int CW = $clog2(WIDTH);

  div_state_e       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] divisor_reg, divisor_next;
  logic             q_neg_reg, q_neg_next;
  logic             r_neg_reg, r_neg_next;
  logic             divz_reg, divz_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic             valid_out_reg, valid_out_next;
  logic             busy_reg, busy_next;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign a_mag = (sign && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign b_mag = (sign && SrcB[WIDTH-1]) ? -SrcB : SrcB;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (divisor_reg),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      divisor_reg   <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      divz_reg      <= 1'b0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      valid_out_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rem_reg       <= rem_next;
      quo_reg       <= quo_next;
      divisor_reg   <= divisor_next;
      q_neg_reg     <= q_neg_next;
      r_neg_reg     <= r_neg_next;
      divz_reg      <= divz_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      valid_out_reg <= valid_out_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rem_next     = rem_reg;
    quo_next     = quo_reg;
    divisor_next = divisor_reg;
    q_neg_next   = q_neg_reg;
    r_neg_next   = r_neg_reg;
    divz_next    = divz_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    case (state_reg)
      IDLE: begin
        if (validIn) begin
          state_next   = BUSY;
          cnt_next     = '0;
          rem_next     = '0;
          quo_next     = a_mag;
          divisor_next = b_mag;
          q_neg_next   = sign & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          r_neg_next   = sign & SrcA[WIDTH-1];
          divz_next    = (SrcB == '0);
        end
      end
      BUSY: begin
        rem_next = step_rem;
        quo_next = step_quo;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
      end
      FIX: begin
        // A zero divisor leaves rem = |A|, so the remainder fix-up restores raw SrcA
        lo_next    = divz_reg ? '1 : (q_neg_reg ? -quo_reg : quo_reg);
        hi_next    = r_neg_reg ? -rem_reg : rem_reg;
        state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    valid_out_next = (state_next == DONE);
    busy_next      = (state_next != IDLE);
  end

  assign validOut = valid_out_reg;
  assign busy     = busy_reg;
  assign Hi       = hi_reg;
  assign Lo       = lo_reg;
endmodule

// File: tb/tb_mips_divider.sv
// Directed vector table plus multi-cycle sequences (reset abort, operand churn, back-to-back).
module tb_mips_divider;
  import mips_div_pkg::*;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         validIn = 1'b0;
  logic         sign = 1'b0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         validOut, busy;
  logic [W-1:0] Hi, Lo;

  always #5 clk = ~clk;

  mips_divider dut (
    .clk      (clk),
    .reset    (reset),
    .validIn  (validIn),
    .sign     (sign),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .validOut (validOut),
    .busy     (busy),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: present a request and count edges until validOut (bounded).
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit scramble, output int lat);
    sign = s; SrcA = a; SrcB = b; validIn = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (scramble) begin
        validIn = 1'b1;
        sign    = 1'($urandom_range(1));
        SrcA    = $urandom;
        SrcB    = $urandom;
      end else begin
        validIn = 1'b0;
      end
    end while (!validOut && lat < 100);
    validIn = 1'b0;
  endtask

  task automatic finish_op(input string tag, input int lat, input logic [W-1:0] lo,
                           input logic [W-1:0] hi);
    chk({tag, "_lat"}, W'(lat), W'(DIV_LAT));
    chk({tag, "_lo"}, Lo, lo);
    chk({tag, "_hi"}, Hi, hi);
    @(posedge clk); @(negedge clk);
    chk({tag, "_pulse"}, W'(validOut), '0);
    chk({tag, "_idle"}, W'(busy), '0);
    $display("op %s: lat=%0d Lo=%h Hi=%h", tag, lat, Lo, Hi);
  endtask

  initial begin
    int lat;
    int n;
    bit stable;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
    vecs[5]  = '{1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678};
    vecs[6]  = '{1'b1, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678};
    vecs[7]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9};
    vecs[8]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1};
    vecs[9]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE};
    vecs[10] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", W'(validOut), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_hi", Hi, '0);
    chk("rst_lo", Lo, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, 1'b0, lat);
      finish_op($sformatf("vec%0d", i), lat, vecs[i].lo, vecs[i].hi);
    end

    // Operands and validIn churn every BUSY cycle; only the captured request matters
    run_op(1'b0, 32'd1000, 32'd33, 1'b1, lat);
    finish_op("scramble", lat, 32'd30, 32'd10);

    // Abort 10 cycles into BUSY, then start in the first cycle after reset drops
    sign = 1'b0; SrcA = 32'hFFFF; SrcB = 32'd5; validIn = 1'b1;
    @(posedge clk); @(negedge clk);
    validIn = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    chk("abort_busy_before", W'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_busy", W'(busy), '0);
    chk("abort_valid", W'(validOut), '0);
    chk("abort_hi", Hi, '0);
    chk("abort_lo", Lo, '0);
    reset = 1'b0;
    run_op(1'b0, 32'd9, 32'd3, 1'b0, lat);
    finish_op("after_reset", lat, 32'd3, 32'd0);

    // Back-to-back: validIn held across validOut
    sign = 1'b0; SrcA = 32'd100; SrcB = 32'd7; validIn = 1'b1;
    n = 0;
    do begin
      @(posedge clk); @(negedge clk);
      n++;
    end while (!validOut && n < 100);
    chk("b2b_first_lat", W'(n), W'(DIV_LAT));
    chk("b2b_first_lo", Lo, 32'd14);
    sign = 1'b1; SrcA = 32'hFFFFFFF9; SrcB = 32'd2;
    n = 0;
    stable = 1'b1;
    do begin
      @(posedge clk); @(negedge clk);
      n++;
      if (!validOut && (Lo !== 32'd14 || Hi !== 32'd2)) stable = 1'b0;
    end while (!validOut && n < 100);
    validIn = 1'b0;
    chk("b2b_gap", W'(n), W'(DIV_LAT + 1));
    chk("b2b_hold", W'(stable), 32'd1);
    chk("b2b_second_lo", Lo, 32'hFFFFFFFD);
    chk("b2b_second_hi", Hi, 32'hFFFFFFFF);
    $display("op b2b: gap=%0d Lo=%h Hi=%h", n, Lo, Hi);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
